// File: rtl/clk_switch_pkg.sv
// rtl/clk_switch_pkg.sv - shared state encoding and parameter defaults for the clock switch controller
package clk_switch_pkg;

  typedef enum logic [2:0] {
    S_CLK0 = 3'd0,
    S_CHK1 = 3'd1,
    S_SET1 = 3'd2,
    S_CLK1 = 3'd3,
    S_SET0 = 3'd4
  } state_e;

  localparam int unsigned WIN_CYCLES_DEF    = 64;
  localparam int unsigned MIN_EDGES_DEF     = 4;
  localparam int unsigned SETTLE_CYCLES_DEF = 16;
  localparam int unsigned CHK_WINDOWS_DEF   = 4;

endpackage

// File: rtl/clk_presence_det.sv
// rtl/clk_presence_det.sv - clk1 presence detector: clk1 divider, clk0 synchroniser, windowed edge count
module clk_presence_det
  import clk_switch_pkg::*;
#(
  parameter int unsigned WIN_CYCLES = WIN_CYCLES_DEF,
  parameter int unsigned MIN_EDGES  = MIN_EDGES_DEF
) (
  input  logic clk0_i,
  input  logic arst_ni,
  input  logic clk1_i,
  output logic win_end_o,
  output logic win_alive_o,
  output logic alive_o
);

  localparam int unsigned WW = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
  localparam int unsigned EW = (MIN_EDGES > 0) ? $clog2(MIN_EDGES + 1) : 1;
  localparam logic [WW-1:0] WIN_LAST = WW'(WIN_CYCLES - 1);
  localparam logic [EW-1:0] EDGE_SAT = EW'(MIN_EDGES);

  logic [2:0]    cnt1_q;
  logic [2:0]    sync_q;
  logic [WW-1:0] win_q, win_d;
  logic [EW-1:0] edge_q, edge_d, edge_inc;
  logic          alive_q, alive_d;
  logic          toggle;

  always_ff @(posedge clk1_i or negedge arst_ni) begin
    if (!arst_ni) cnt1_q <= 3'd0;
    else          cnt1_q <= cnt1_q + 3'd1;
  end

  // sync_q[1:0] is the two-flop synchroniser, sync_q[2] the edge-detect history
  assign toggle = sync_q[1] ^ sync_q[2];

  always_comb begin
    edge_inc = edge_q;
    if (toggle && (edge_q != EDGE_SAT)) edge_inc = edge_q + 1'b1;
    win_end_o   = (win_q == WIN_LAST);
    win_alive_o = (edge_inc >= EDGE_SAT);
    win_d       = win_end_o ? '0 : win_q + 1'b1;
    edge_d      = win_end_o ? '0 : edge_inc;
    alive_d     = win_end_o ? win_alive_o : alive_q;
  end

  always_ff @(posedge clk0_i or negedge arst_ni) begin
    if (!arst_ni) begin
      sync_q  <= 3'd0;
      win_q   <= '0;
      edge_q  <= '0;
      alive_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], cnt1_q[2]};
      win_q   <= win_d;
      edge_q  <= edge_d;
      alive_q <= alive_d;
    end
  end

  assign alive_o = alive_q;

endmodule

// File: rtl/clk_switch_ctrl.sv
// rtl/clk_switch_ctrl.sv - clk0/clk1 source select sequencer with clk1 presence check and automatic fallback
module clk_switch_ctrl
  import clk_switch_pkg::*;
#(
  parameter int unsigned WIN_CYCLES    = WIN_CYCLES_DEF,
  parameter int unsigned MIN_EDGES     = MIN_EDGES_DEF,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int unsigned CHK_WINDOWS   = CHK_WINDOWS_DEF
) (
  input  logic clk0_i,
  input  logic arst_ni,
  input  logic clk1_i,
  input  logic req_valid_i,
  input  logic req_sel_i,
  output logic req_ready_o,
  output logic sel_o,
  output logic done_o,
  output logic err_o,
  output logic fail_o,
  output logic clk1_alive_o
);

  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned CW = (CHK_WINDOWS > 1) ? $clog2(CHK_WINDOWS) : 1;
  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] CHK_LAST = CW'(CHK_WINDOWS - 1);

  state_e        state_q, state_d;
  logic [SW-1:0] set_q, set_d;
  logic [CW-1:0] chk_q, chk_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          fail_q, fail_d;
  logic          pend_q, pend_d;
  logic          rdy_q;
  logic          win_end, win_alive, alive;
  logic          accept;

  clk_presence_det #(
    .WIN_CYCLES (WIN_CYCLES),
    .MIN_EDGES  (MIN_EDGES)
  ) u_det (
    .clk0_i      (clk0_i),
    .arst_ni     (arst_ni),
    .clk1_i      (clk1_i),
    .win_end_o   (win_end),
    .win_alive_o (win_alive),
    .alive_o     (alive)
  );

  // In S_CLK1 a dead clk1 takes priority, so no request is accepted that cycle
  assign req_ready_o = rdy_q & ((state_q == S_CLK0) | ((state_q == S_CLK1) & alive));
  assign accept      = req_valid_i & req_ready_o;
  assign sel_o       = (state_q == S_SET1) | (state_q == S_CLK1);

  always_comb begin
    state_d = state_q;
    set_d   = set_q;
    chk_d   = chk_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    fail_d  = fail_q;
    pend_d  = pend_q;
    if (accept) fail_d = 1'b0;
    case (state_q)
      S_CLK0: begin
        if (accept) begin
          if (!req_sel_i) begin
            done_d = 1'b1;
          end else begin
            pend_d  = 1'b1;
            set_d   = '0;
            chk_d   = '0;
            state_d = alive ? S_SET1 : S_CHK1;
          end
        end
      end
      S_CHK1: begin
        if (win_end) begin
          if (win_alive) begin
            set_d   = '0;
            state_d = S_SET1;
          end else if (chk_q == CHK_LAST) begin
            err_d   = 1'b1;
            pend_d  = 1'b0;
            state_d = S_CLK0;
          end else begin
            chk_d = chk_q + 1'b1;
          end
        end
      end
      S_SET1: begin
        if (!alive) begin
          fail_d  = 1'b1;
          set_d   = '0;
          state_d = S_SET0;
        end else if (set_q == SET_LAST) begin
          done_d  = 1'b1;
          pend_d  = 1'b0;
          state_d = S_CLK1;
        end else begin
          set_d = set_q + 1'b1;
        end
      end
      S_CLK1: begin
        if (!alive) begin
          fail_d  = 1'b1;
          set_d   = '0;
          state_d = S_SET0;
        end else if (accept) begin
          if (req_sel_i) begin
            done_d = 1'b1;
          end else begin
            pend_d  = 1'b1;
            set_d   = '0;
            state_d = S_SET0;
          end
        end
      end
      S_SET0: begin
        if (set_q == SET_LAST) begin
          done_d  = pend_q;
          pend_d  = 1'b0;
          state_d = S_CLK0;
        end else begin
          set_d = set_q + 1'b1;
        end
      end
      default: state_d = S_CLK0;
    endcase
  end

  always_ff @(posedge clk0_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= S_CLK0;
      set_q   <= '0;
      chk_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      fail_q  <= 1'b0;
      pend_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      chk_q   <= chk_d;
      done_q  <= done_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      pend_q  <= pend_d;
      rdy_q   <= 1'b1;
    end
  end

  assign done_o       = done_q;
  assign err_o        = err_q;
  assign fail_o       = fail_q;
  assign clk1_alive_o = alive;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// tb/tb_clk_switch_ctrl.sv - directed self-checking bench for clk_switch_ctrl
`timescale 1ns/1ps
module tb_clk_switch_ctrl;

  logic clk0_i = 1'b0;
  logic clk1_i = 1'b0;
  logic arst_ni = 1'b0;
  logic req_valid_i = 1'b0;
  logic req_sel_i = 1'b0;
  logic req_ready_o, sel_o, done_o, err_o, fail_o, clk1_alive_o;

  int  checks = 0;
  int  errors = 0;
  real clk1_half = 12.5;
  bit  clk1_en = 1'b1;
  logic acc_a, acc_b, acc_c;

  clk_switch_ctrl dut (
    .clk0_i       (clk0_i),
    .arst_ni      (arst_ni),
    .clk1_i       (clk1_i),
    .req_valid_i  (req_valid_i),
    .req_sel_i    (req_sel_i),
    .req_ready_o  (req_ready_o),
    .sel_o        (sel_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .fail_o       (fail_o),
    .clk1_alive_o (clk1_alive_o)
  );

  always #5 clk0_i = ~clk0_i;

  always begin
    if (clk1_en) #(clk1_half) clk1_i = ~clk1_i;
    else #1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_alive(input string tag);
    for (int i = 0; i < 300 && !clk1_alive_o; i++) @(negedge clk0_i);
    check(tag, clk1_alive_o, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // reset values
    repeat (3) @(negedge clk0_i);
    check("rst_sel", sel_o, 0);
    check("rst_ready", req_ready_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_fail", fail_o, 0);
    check("rst_alive", clk1_alive_o, 0);
    arst_ni = 1'b1;
    check("ready_before_edge", req_ready_o, 0);
    @(negedge clk0_i);
    check("ready_after_release", req_ready_o, 1);

    // sel=0 request while on clk0
    req_valid_i = 1'b1; req_sel_i = 1'b0;
    @(negedge clk0_i);
    req_valid_i = 1'b0;
    check("clk0_req0_done", done_o, 1);
    check("clk0_req0_sel", sel_o, 0);
    @(negedge clk0_i);
    check("clk0_req0_done_clr", done_o, 0);
    check("clk0_req0_sel_hold", sel_o, 0);

    // switch to clk1 with clk1 alive
    wait_alive("alive_40mhz");
    req_valid_i = 1'b1; req_sel_i = 1'b1;
    @(negedge clk0_i);
    req_valid_i = 1'b0;
    check("set1_sel_rise", sel_o, 1);
    check("set1_ready_low", req_ready_o, 0);
    check("set1_done_low", done_o, 0);
    acc_a = 1'b0; acc_b = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk0_i);
      acc_a |= done_o;
      acc_b |= ~sel_o;
    end
    check("set1_no_early_done", acc_a, 0);
    check("set1_sel_steady", acc_b, 0);
    @(negedge clk0_i);
    check("set1_done", done_o, 1);
    check("set1_sel", sel_o, 1);
    @(negedge clk0_i);
    check("clk1_done_clr", done_o, 0);
    check("clk1_ready", req_ready_o, 1);

    // sel=1 request while on clk1
    req_valid_i = 1'b1; req_sel_i = 1'b1;
    @(negedge clk0_i);
    req_valid_i = 1'b0;
    check("clk1_req1_done", done_o, 1);
    check("clk1_req1_sel", sel_o, 1);

    // back to clk0
    @(negedge clk0_i);
    req_valid_i = 1'b1; req_sel_i = 1'b0;
    @(negedge clk0_i);
    req_valid_i = 1'b0;
    check("set0_sel_fall", sel_o, 0);
    acc_a = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk0_i);
      acc_a |= done_o;
    end
    check("set0_no_early_done", acc_a, 0);
    @(negedge clk0_i);
    check("set0_done", done_o, 1);
    check("set0_fail", fail_o, 0);

    // clk1 stopped: request to clk1 must error after four windows
    clk1_en = 1'b0;
    for (int i = 0; i < 300 && clk1_alive_o; i++) @(negedge clk0_i);
    check("alive_fall", clk1_alive_o, 0);
    req_valid_i = 1'b1; req_sel_i = 1'b1;
    @(negedge clk0_i);
    req_valid_i = 1'b0;
    check("chk1_sel", sel_o, 0);
    check("chk1_ready", req_ready_o, 0);
    acc_a = 1'b0; acc_b = 1'b0; acc_c = 1'b0;
    for (int i = 0; i < 254; i++) begin
      @(negedge clk0_i);
      acc_a |= err_o;
      acc_b |= done_o;
      acc_c |= sel_o;
    end
    check("chk1_no_early_err", acc_a, 0);
    check("chk1_no_done", acc_b, 0);
    check("chk1_sel_low", acc_c, 0);
    @(negedge clk0_i);
    check("chk1_err", err_o, 1);
    check("chk1_err_no_done", done_o, 0);
    check("chk1_err_sel", sel_o, 0);
    @(negedge clk0_i);
    check("chk1_err_clr", err_o, 0);
    check("chk1_ready_back", req_ready_o, 1);

    // clk1 loss while on clk1: automatic fallback
    clk1_half = 12.5; clk1_en = 1'b1;
    wait_alive("alive_restart");
    req_valid_i = 1'b1; req_sel_i = 1'b1;
    @(negedge clk0_i);
    req_valid_i = 1'b0;
    for (int i = 0; i < 30 && !done_o; i++) @(negedge clk0_i);
    check("fb_reach_clk1", done_o, 1);
    clk1_en = 1'b0;
    for (int i = 0; i < 160 && sel_o; i++) @(negedge clk0_i);
    check("fb_sel_low", sel_o, 0);
    check("fb_fail_set", fail_o, 1);
    check("fb_alive_low", clk1_alive_o, 0);
    acc_a = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk0_i);
      acc_a |= done_o;
    end
    check("fb_no_done", acc_a, 0);
    check("fb_fail_sticky", fail_o, 1);
    check("fb_ready", req_ready_o, 1);
    req_valid_i = 1'b1; req_sel_i = 1'b0;
    @(negedge clk0_i);
    req_valid_i = 1'b0;
    check("fb_fail_clear", fail_o, 0);
    check("fb_req_done", done_o, 1);

    // reset in the middle of a switch to clk1
    clk1_en = 1'b1;
    wait_alive("alive_before_rst");
    req_valid_i = 1'b1; req_sel_i = 1'b1;
    @(negedge clk0_i);
    req_valid_i = 1'b0;
    repeat (4) @(negedge clk0_i);
    check("midrst_in_set1", sel_o, 1);
    #2 arst_ni = 1'b0;
    #1;
    check("midrst_sel", sel_o, 0);
    check("midrst_ready", req_ready_o, 0);
    check("midrst_done", done_o, 0);
    check("midrst_err", err_o, 0);
    check("midrst_fail", fail_o, 0);
    check("midrst_alive", clk1_alive_o, 0);
    @(negedge clk0_i);
    arst_ni = 1'b1;
    @(negedge clk0_i);
    check("midrst_ready_back", req_ready_o, 1);
    check("midrst_sel_back", sel_o, 0);
    check("midrst_no_done", done_o, 0);

    // fast clk1: alive right after the first full window
    arst_ni = 1'b0;
    clk1_half = 2.0;
    repeat (3) @(negedge clk0_i);
    arst_ni = 1'b1;
    repeat (63) @(negedge clk0_i);
    check("fast_alive_before_end", clk1_alive_o, 0);
    @(negedge clk0_i);
    check("fast_alive_window1", clk1_alive_o, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_switch_ctrl.md
CLK_SWITCH_CTRL -- requirements
Module: clk_switch_ctrl

Interface
REQ-001 SHALL take parameter WIN_CYCLES, default 64: clk0 cycles per clk1 presence-check window.
REQ-002 SHALL take parameter MIN_EDGES, default 4: synced divided-clk1 transitions per window needed to declare clk1 alive.
REQ-003 SHALL take parameter SETTLE_CYCLES, default 16: clk0 cycles waited after a sel_o change before completion.
REQ-004 SHALL take parameter CHK_WINDOWS, default 4: failed windows tolerated before a switch-to-clk1 request errors.
REQ-005 SHALL have port clk0_i, input, 1, the block clock and the always-on primary clock.
REQ-006 SHALL have port arst_ni, input, 1, reset: asynchronous, active-low.
REQ-007 SHALL have port clk1_i, input, 1, the monitored secondary clock.
REQ-008 SHALL have port req_valid_i, input, 1, switch request valid.
REQ-009 SHALL have port req_sel_i, input, 1, requested source: 0 = clk0, 1 = clk1.
REQ-010 SHALL have port req_ready_o, output, 1, request accept.
REQ-011 SHALL have port sel_o, output, 1, select to the downstream glitch-free clock mux.
REQ-012 SHALL have port done_o, output, 1, one-cycle pulse when a request completes.
REQ-013 SHALL have port err_o, output, 1, one-cycle pulse when a switch to clk1 is refused.
REQ-014 SHALL have port fail_o, output, 1, sticky flag set by automatic fallback after clk1 loss.
REQ-015 SHALL have port clk1_alive_o, output, 1, registered clk1 presence status.

Function
REQ-016 A request SHALL transfer on a clk0 posedge where req_valid_i and req_ready_o are both 1.
REQ-017 req_ready_o SHALL be 1 only in states S_CLK0 and S_CLK1.
REQ-018 Presence detector: a 3-bit free-running counter clocked by clk1_i SHALL have its MSB synchronised into clk0 by 2 flops, then edge-detected by a third flop.
REQ-019 Each window of WIN_CYCLES clk0 cycles SHALL count synced transitions, saturating at MIN_EDGES.
REQ-020 At window end, clk1_alive_o SHALL load (count >= MIN_EDGES), and the count SHALL clear.
REQ-021 FSM states: S_CLK0, S_CHK1, S_SET1, S_CLK1, S_SET0.
REQ-022 S_CLK0: sel_o = 0.
  - Accepted req_sel_i = 0: done_o pulses the next cycle; state stays S_CLK0.
  - Accepted req_sel_i = 1 with clk1_alive_o = 1: go to S_SET1.
  - Accepted req_sel_i = 1 with clk1_alive_o = 0: go to S_CHK1.
REQ-023 S_CHK1 SHALL go to S_SET1 at the first window end reporting alive.
  - After CHK_WINDOWS window ends with no alive report, it SHALL pulse err_o and return to S_CLK0 with sel_o = 0.
REQ-024 S_SET1 SHALL drive sel_o = 1, count SETTLE_CYCLES cycles, then pulse done_o and enter S_CLK1.
REQ-025 S_CLK1: sel_o = 1.
  - Accepted req_sel_i = 1: done_o pulses; state stays S_CLK1.
  - Accepted req_sel_i = 0: go to S_SET0.
REQ-026 S_SET0 SHALL drive sel_o = 0, count SETTLE_CYCLES cycles, then pulse done_o and enter S_CLK0.
REQ-027 In S_CLK1 or S_SET1, clk1_alive_o falling SHALL cause, on the next cycle:
  - sel_o = 0;
  - fail_o set;
  - a move to S_SET0.
  - The S_SET0 exit SHALL then produce no done_o unless a request was outstanding.
REQ-028 fail_o SHALL clear only when a new request is accepted.
REQ-029 A request accepted in the same cycle as a window end SHALL use the pre-update clk1_alive_o value.
REQ-030 done_o and err_o SHALL never assert in the same cycle.
REQ-031 sel_o SHALL change at most once per SETTLE_CYCLES + 1 cycles.
REQ-032 Window and settle counters SHALL be $clog2-sized, with no wrap beyond their terminal values.

Reset
REQ-033 Reset SHALL force state S_CLK0 and all counters to 0.
REQ-034 Reset SHALL force sel_o = 0, req_ready_o = 0, done_o = 0, err_o = 0, fail_o = 0 and clk1_alive_o = 0.
REQ-035 req_ready_o SHALL rise on the first clk0 posedge after reset release.
REQ-036 The clk1-domain counter SHALL also reset on arst_ni.
REQ-037 Reset asserted mid-switch SHALL abandon the switch with no done_o or err_o.

Structure
REQ-038 Package clk_switch_pkg SHALL hold:
  - the state enum;
  - default values of WIN_CYCLES, MIN_EDGES, SETTLE_CYCLES and CHK_WINDOWS.
REQ-039 The presence detector (clk1 counter, synchroniser, window logic) SHALL be sub-module clk_presence_det, instantiated once.

Verification
REQ-040 clk0 100 MHz, clk1 40 MHz running, request sel = 1 after alive:
  - sel_o rises 1 cycle after accept;
  - done_o pulses 16 cycles later;
  - state S_CLK1.
REQ-041 clk1 stopped, request sel = 1:
  - err_o pulses after 4 window ends (256 cycles);
  - sel_o stays 0;
  - no done_o.
REQ-042 In S_CLK1, stop clk1:
  - within 2 windows sel_o = 0 and fail_o = 1;
  - a later accepted request clears fail_o.
REQ-043 Request sel = 0 while in S_CLK0: done_o pulses the next cycle, and sel_o does not toggle.
REQ-044 Assert arst_ni low during S_SET1:
  - all outputs go to reset values immediately;
  - after release, req_ready_o = 1 and sel_o = 0.
REQ-045 clk1 at 250 MHz (faster than clk0): clk1_alive_o = 1 after the first full window.
